accum_adder: RTL and testbench

ACCUM_ADDER -- requirements
Module: accum_adder

---
 rtl/accum_pkg.sv | 14 +
 rtl/accum_ext.sv | 17 +
 rtl/accum_adder.sv | 108 ++++++++++
 tb/tb_accum_adder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulating adder: FSM state encoding and
// default operand width / transaction length.
package accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH     = 32;
   localparam int DEFAULT_MAX_TERMS = 16;

endpackage

// File: rtl/accum_ext.sv
// Widens an operand from WIDTH to SW bits before accumulation.
// Sign-extends when ACCUM_SIGNED_EN is defined, zero-extends otherwise.
module accum_ext #(
   parameter int WIDTH = 32,
   parameter int SW    = 36
) (
   input  logic [WIDTH-1:0] din,
   output logic [SW-1:0]    dout
);

`ifdef ACCUM_SIGNED_EN
   assign dout = {{(SW-WIDTH){din[WIDTH-1]}}, din};
`else
   assign dout = {{(SW-WIDTH){1'b0}}, din};
`endif

endmodule

// File: rtl/accum_adder.sv
// Sums a variable-length stream of operands (closed by in_last or after
// MAX_TERMS beats) and presents sum, count and truncation flag downstream.
// Build option: define ACCUM_SIGNED_EN for two's-complement operands.
module accum_adder
   import accum_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MAX_TERMS = DEFAULT_MAX_TERMS,
   localparam int SW       = WIDTH + $clog2(MAX_TERMS),
   localparam int CW       = $clog2(MAX_TERMS) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SW-1:0]    out_sum,
   output logic [CW-1:0]    out_count,
   output logic             out_trunc
);

   state_t        state, state_nxt;
   logic [SW-1:0] acc, acc_nxt;
   logic [CW-1:0] count, count_nxt;
   logic          trunc, trunc_nxt;
   logic [SW-1:0] ext_data;

   accum_ext #(
      .WIDTH (WIDTH),
      .SW    (SW)
   ) u_ext (
      .din  (in_data),
      .dout (ext_data)
   );

   // Reset has priority, so an operand offered during reset is never taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         trunc <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         count <= count_nxt;
         trunc <= trunc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      count_nxt = count;
      trunc_nxt = trunc;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_nxt   = ext_data;
               count_nxt = CW'(1);
               trunc_nxt = 1'b0;
               state_nxt = in_last ? DONE : ACCUM;
            end
         end

         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_nxt   = acc + ext_data;
               count_nxt = count + CW'(1);
               if (in_last) begin
                  state_nxt = DONE;
               end else if (count_nxt == CW'(MAX_TERMS)) begin
                  // Closed by length rather than by the producer
                  state_nxt = DONE;
                  trunc_nxt = 1'b1;
               end
            end
         end

         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
               acc_nxt   = '0;
               count_nxt = '0;
               trunc_nxt = 1'b0;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign out_sum   = acc;
   assign out_count = count;
   assign out_trunc = trunc;

endmodule

// File: tb/tb_accum_adder.sv
// Self-checking bench for accum_adder (WIDTH=8, MAX_TERMS=4) using a
// transaction-level reference model; honours ACCUM_SIGNED_EN when defined.
module tb_accum_adder;

   localparam int WIDTH     = 8;
   localparam int MAX_TERMS = 4;
   localparam int SW        = WIDTH + $clog2(MAX_TERMS);
   localparam int CW        = $clog2(MAX_TERMS) + 1;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [SW-1:0]    out_sum;
   logic [CW-1:0]    out_count;
   logic             out_trunc;

   accum_adder #(
      .WIDTH     (WIDTH),
      .MAX_TERMS (MAX_TERMS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_trunc (out_trunc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: operands of the open transaction plus the pending result
   logic [WIDTH-1:0] open_q[$];
   bit               pending;
   logic [SW-1:0]    exp_sum;
   int               exp_count;
   bit               exp_trunc;
   int               checks;
   int               errors;

   function automatic logic [SW-1:0] ref_sum();
      longint s = 0;
      foreach (open_q[i]) begin
`ifdef ACCUM_SIGNED_EN
         s += longint'($signed(open_q[i]));
`else
         s += longint'(open_q[i]);
`endif
      end
      return SW'(s);
   endfunction

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check outputs after it
   task automatic applyStimulus(input bit r, input bit v, input logic [WIDTH-1:0] d,
                                input bit l, input bit o, output bit accepted);
      rst       = r;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = o;
      accepted  = !r && v && !pending;
      @(posedge clk);
      if (r) begin
         open_q.delete();
         pending = 1'b0;
      end else if (pending) begin
         if (o) pending = 1'b0;
      end else if (v) begin
         open_q.push_back(d);
         if (l || open_q.size() == MAX_TERMS) begin
            pending   = 1'b1;
            exp_sum   = ref_sum();
            exp_count = open_q.size();
            exp_trunc = !l;
            open_q.delete();
         end
      end
      @(negedge clk);
      checkOutput("out_valid", longint'(out_valid), longint'(pending));
      checkOutput("in_ready", longint'(in_ready), longint'(!pending));
      if (pending) begin
         checkOutput("out_sum", longint'(out_sum), longint'(exp_sum));
         checkOutput("out_count", longint'(out_count), longint'(exp_count));
         checkOutput("out_trunc", longint'(out_trunc), longint'(exp_trunc));
      end
   endtask

   task automatic feed(input logic [WIDTH-1:0] d, input bit l);
      bit acc;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, d, l, 1'b1, acc);
         if (acc) return;
      end
      checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic idle_cycle(input bit o);
      bit acc;
      applyStimulus(1'b0, 1'b0, 8'hA5, 1'b1, o, acc);
   endtask

   initial begin
      bit acc;
      checks  = 0;
      errors  = 0;
      pending = 1'b0;

      // Reset held two cycles with a valid, final operand offered
      applyStimulus(1'b1, 1'b1, 8'd55, 1'b1, 1'b1, acc);
      applyStimulus(1'b1, 1'b1, 8'd55, 1'b1, 1'b1, acc);
      checkOutput("reset_out_valid", longint'(out_valid), 0);
      checkOutput("reset_in_ready", longint'(in_ready), 1);
      idle_cycle(1'b1);

      // Pair
      feed(8'd102, 1'b0);
      feed(8'd188, 1'b1);
`ifdef ACCUM_SIGNED_EN
      checkOutput("pair_sum", longint'(out_sum), 34);
`else
      checkOutput("pair_sum", longint'(out_sum), 290);
`endif
      checkOutput("pair_count", longint'(out_count), 2);
      checkOutput("pair_trunc", longint'(out_trunc), 0);
      idle_cycle(1'b1);

      // Single operand, result visible the cycle after acceptance
      feed(8'd145, 1'b1);
      checkOutput("single_valid", longint'(out_valid), 1);
`ifdef ACCUM_SIGNED_EN
      checkOutput("single_sum", longint'(out_sum), 913);
`else
      checkOutput("single_sum", longint'(out_sum), 145);
`endif
      checkOutput("single_count", longint'(out_count), 1);
      idle_cycle(1'b1);

      // Truncation at MAX_TERMS, then backpressure with the fifth beat waiting
      repeat (4) feed(8'd200, 1'b0);
      checkOutput("trunc_sum", longint'(out_sum), 800);
      checkOutput("trunc_count", longint'(out_count), 4);
      checkOutput("trunc_flag", longint'(out_trunc), 1);
      repeat (3) begin
         applyStimulus(1'b0, 1'b1, 8'd200, 1'b0, 1'b0, acc);
         checkOutput("bp_in_ready", longint'(in_ready), 0);
         checkOutput("bp_sum_hold", longint'(out_sum), 800);
      end
      applyStimulus(1'b0, 1'b1, 8'd200, 1'b0, 1'b1, acc);
      checkOutput("bp_taken_ready", longint'(in_ready), 1);
      checkOutput("bp_taken_valid", longint'(out_valid), 0);
      feed(8'd200, 1'b0);
      feed(8'd7, 1'b1);
      checkOutput("fifth_beat_count", longint'(out_count), 2);
      idle_cycle(1'b1);

      // in_last on the MAX_TERMS-th operand is not a truncation
      repeat (3) feed(8'd1, 1'b0);
      feed(8'd1, 1'b1);
      checkOutput("full_last_trunc", longint'(out_trunc), 0);
      checkOutput("full_last_count", longint'(out_count), 4);
      idle_cycle(1'b1);

      // Sign handling
      feed(8'hFB, 1'b0);
      feed(8'h03, 1'b1);
`ifdef ACCUM_SIGNED_EN
      checkOutput("sign_sum", longint'(out_sum), 1022);
`else
      checkOutput("sign_sum", longint'(out_sum), 254);
`endif
      idle_cycle(1'b1);

      // Reset mid-transaction discards the partial sum
      feed(8'd10, 1'b0);
      feed(8'd20, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, acc);
      checkOutput("midrst_valid", longint'(out_valid), 0);
      feed(8'd9, 1'b1);
      checkOutput("midrst_sum", longint'(out_sum), 9);
      checkOutput("midrst_count", longint'(out_count), 1);
      idle_cycle(1'b1);

      // Randomized traffic
      repeat (2000) begin
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                       8'($urandom), $urandom_range(0, 9) < 3,
                       $urandom_range(0, 9) < 6, acc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
